wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Write-back stage of the 5-stage RV32I pipeline.
- Registers the MEM/WB pipeline bundle and selects the result source: ALU result, load data or pc+4.
- Performs load byte/halfword extraction and sign/zero extension.
- Drives the register-file write port (rdw, wew, wdw) consumed by the decode stage.
- Holds the pipeline via stall_req while a load's memory response is outstanding; also provides forwarding info and a retired-instruction counter.

Parameters:
DATA_WIDTH, 32, datapath and register width
ADDR_WIDTH, 32, pc width
CNT_WIDTH, 64, width of retired-instruction counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset
en  input  1  pipeline advance enable; MEM/WB register loads only when en=1 and stall_req=0
flush  input  1  synchronous kill of the instruction held in the WB register
in_valid  input  1  MEM-stage bundle valid
in_rd  input  5  destination register
in_reg_we  input  1  instruction writes rd
in_wb_ctr  input  2  result select: 00 alu, 01 load, 10 pc+4, 11 treated as alu
in_op  input  3  load funct3
in_alu_res  input  DATA_WIDTH  ALU result / effective address
in_pcn  input  ADDR_WIDTH  pc+4 of the instruction
mem_rsp_valid  input  1  load data valid this cycle
mem_rsp_data  input  DATA_WIDTH  aligned 32-bit word containing the load
rdw  output  5  register-file write address
wew  output  1  register-file write enable
wdw  output  DATA_WIDTH  register-file write data
stall_req  output  1  hold upstream stages
fwd_valid  output  1  WB holds a result usable for forwarding this cycle
fwd_rd  output  5  forwarding destination
fwd_data  output  DATA_WIDTH  forwarding data (equal to wdw)
instret  output  CNT_WIDTH  count of retired valid instructions

Behaviour:
- Reset (rst=0, asynchronous):
  - WB register valid=0, all fields 0.
  - FSM=IDLE, instret=0.
  - Outputs: wew=0, stall_req=0, fwd_valid=0, rdw=0, wdw=0.
- Capture: on a rising edge with en=1 and stall_req=0, the WB register loads in_* (valid<=in_valid).
  - flush=1 on the same edge forces valid<=0 and has priority over capture.
  - If en=0 and no flush, the register holds its contents.
- Latency: a non-load result is written in the cycle after capture (one-cycle MEM->WB).
- FSM states are IDLE and WAIT_MEM.
  - IDLE, register valid with wb_ctr!=01: writeback is combinational from the register. wew=reg_we&&(rd!=0). The instruction retires this cycle.
  - IDLE, register valid with wb_ctr=01, mem_rsp_valid=1 in the same cycle: the load writes back this cycle with wdw taken from mem_rsp_data. It retires and the FSM stays in IDLE.
  - IDLE, register valid with wb_ctr=01, mem_rsp_valid=0: stall_req=1 combinationally, wew=0, next state WAIT_MEM.
  - WAIT_MEM: stall_req=1 and wew=0 until mem_rsp_valid=1.
  - WAIT_MEM, response cycle: write back (wew=reg_we&&rd!=0), stall_req=0, retire, next state IDLE. The next bundle may be captured on that same edge.
  - mem_rsp_valid while no load is pending is ignored.
- Load extraction: byte lane = alu_res[1:0]; halfword lane = alu_res[1].
  - 000 LB: sign-extend the byte.
  - 001 LH: sign-extend the halfword.
  - 100 LBU: zero-extend the byte.
  - 101 LHU: zero-extend the halfword.
  - 010 LW and all other encodings: full word.
- rd=0 is never written (wew=0), but the instruction still retires and increments instret.
- Forwarding outputs:
  - fwd_valid=wew.
  - fwd_rd=rdw.
  - fwd_data=wdw.
  - While stalled in WAIT_MEM, fwd_valid=0.
- instret: +1 on every cycle in which a valid instruction completes write-back (including rd=0 and reg_we=0). It wraps modulo 2^CNT_WIDTH.
- Flush vs. load:
  - flush while in WAIT_MEM drops the load: valid<=0, FSM<=IDLE, no write, no retire.
  - A mem_rsp_valid on that same cycle is discarded.
- Reset mid-WAIT_MEM returns to IDLE immediately, with stall_req deasserting asynchronously.

Test Plan:
- ALU write: capture rd=5, reg_we=1, wb_ctr=00, alu_res=0x1234 -> next cycle rdw=5, wew=1, wdw=0x1234, instret 0->1.
- JAL link: wb_ctr=10, pcn=0x00000104, rd=1 -> wew=1, wdw=0x00000104; rd=0 variant -> wew=0, instret still increments.
- Load with 3-cycle memory latency: LB, alu_res[1:0]=2'b11, rsp_data=0x80FF_0000 arriving on the 3rd cycle:
  - stall_req=1 for 2 cycles with wew=0.
  - Response cycle: wdw=0xFFFF_FF80, wew=1, stall_req=0.
  - The next bundle is captured on that edge.
- Extension matrix with rsp_data=0x8001_F07F, same-cycle response:
  - LBU lane0 -> 0x0000007F; LB lane1 -> 0xFFFFFFF0.
  - LH lane1 -> 0xFFFF8001; LHU lane0 -> 0x0000F07F.
  - LW -> 0x8001F07F.
- Flush during WAIT_MEM, plus stray mem_rsp_valid:
  - flush=1 while stalled -> stall_req=0 next cycle, no write, instret unchanged.
  - A later stray mem_rsp_valid -> ignored.
- Async reset while stall_req=1 (rst low mid-cycle) -> stall_req, wew, instret go to 0 without waiting for a clk edge; after release, capture resumes normally.

Source files
------------

// File: rtl/wb_stage.sv
// RV32I write-back stage: MEM/WB register, result select, load extension,
// register-file write port, load stall, forwarding and retire counter.
module wb_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [4:0]            in_rd,
  input  logic                  in_reg_we,
  input  logic [1:0]            in_wb_ctr,
  input  logic [2:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_alu_res,
  input  logic [ADDR_WIDTH-1:0] in_pcn,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic [4:0]            rdw,
  output logic                  wew,
  output logic [DATA_WIDTH-1:0] wdw,
  output logic                  stall_req,
  output logic                  fwd_valid,
  output logic [4:0]            fwd_rd,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic [CNT_WIDTH-1:0]  instret
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_MEM = 1'b1;

  logic                  valid_q;
  logic [4:0]            rd_q;
  logic                  reg_we_q;
  logic [1:0]            wb_ctr_q;
  logic [2:0]            op_q;
  logic [DATA_WIDTH-1:0] alu_q;
  logic [ADDR_WIDTH-1:0] pcn_q;
  logic [0:0]            state_q, state_d;
  logic [CNT_WIDTH-1:0]  instret_q;

  logic                  is_ld;
  logic                  is_jal;
  logic                  done;
  logic                  stall;
  logic                  capture;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [DATA_WIDTH-1:0] res;

  assign is_ld  = (wb_ctr_q == 2'b01);
  assign is_jal = (wb_ctr_q == 2'b10);

  always_comb begin
    done    = 1'b0;
    stall   = 1'b0;
    state_d = state_q;
    if (valid_q) begin
      if (state_q == WAIT_MEM) begin
        stall = !mem_rsp_valid || flush;
        done  = mem_rsp_valid && !flush;
        if (mem_rsp_valid || flush) begin
          state_d = IDLE;
        end
      end else if (is_ld) begin
        if (mem_rsp_valid) begin
          done = !flush;
        end else begin
          stall = 1'b1;
          if (!flush) begin
            state_d = WAIT_MEM;
          end
        end
      end else begin
        done = !flush;
      end
    end
  end

  always_comb begin
    byte_v = 8'(mem_rsp_data >> {alu_q[1:0], 3'b000});
    half_v = 16'(mem_rsp_data >> {alu_q[1], 4'b0000});
    unique case (op_q)
      3'b000:  ld_data = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
      3'b001:  ld_data = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
      3'b100:  ld_data = {{(DATA_WIDTH-8){1'b0}}, byte_v};
      3'b101:  ld_data = {{(DATA_WIDTH-16){1'b0}}, half_v};
      default: ld_data = mem_rsp_data;
    endcase
  end

  always_comb begin
    unique case (1'b1)
      is_ld:   res = ld_data;
      is_jal:  res = DATA_WIDTH'(pcn_q);
      default: res = alu_q;
    endcase
  end

  assign capture = en && !stall;

  // A retired entry drops valid so a frozen pipeline does not retire it twice
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      rd_q     <= '0;
      reg_we_q <= 1'b0;
      wb_ctr_q <= '0;
      op_q     <= '0;
      alu_q    <= '0;
      pcn_q    <= '0;
    end else if (flush) begin
      valid_q  <= 1'b0;
    end else if (capture) begin
      valid_q  <= in_valid;
      rd_q     <= in_rd;
      reg_we_q <= in_reg_we;
      wb_ctr_q <= in_wb_ctr;
      op_q     <= in_op;
      alu_q    <= in_alu_res;
      pcn_q    <= in_pcn;
    end else if (done) begin
      valid_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (done) begin
        instret_q <= instret_q + 1'b1;
      end
    end
  end

  assign rdw       = rd_q;
  assign wew       = done && reg_we_q && (rd_q != 5'd0);
  assign wdw       = res;
  assign stall_req = stall;
  assign fwd_valid = wew;
  assign fwd_rd    = rdw;
  assign fwd_data  = wdw;
  assign instret   = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus queues expected writes,
// a negedge monitor pops and compares whenever wew is presented.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        flush;
  logic        in_valid;
  logic [4:0]  in_rd;
  logic        in_reg_we;
  logic [1:0]  in_wb_ctr;
  logic [2:0]  in_op;
  logic [31:0] in_alu_res;
  logic [31:0] in_pcn;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [4:0]  rdw;
  logic        wew;
  logic [31:0] wdw;
  logic        stall_req;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic [63:0] instret;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  wb_stage dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .in_valid(in_valid), .in_rd(in_rd),
    .in_reg_we(in_reg_we), .in_wb_ctr(in_wb_ctr),
    .in_op(in_op), .in_alu_res(in_alu_res),
    .in_pcn(in_pcn), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .rdw(rdw), .wew(wew),
    .wdw(wdw), .stall_req(stall_req),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] d);
    exp_t e;
    e.rd = rd;
    e.d  = d;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [4:0]  rd,
                      input logic        we,
                      input logic [1:0]  ctr,
                      input logic [2:0]  op,
                      input logic [31:0] alu,
                      input logic [31:0] pcn);
    in_valid   = 1'b1;
    in_rd      = rd;
    in_reg_we  = we;
    in_wb_ctr  = ctr;
    in_op      = op;
    in_alu_res = alu;
    in_pcn     = pcn;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst && wew) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL stray_write: got rd=%0d data=%h want none",
                 rdw, wdw);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_rdw", 64'(rdw), 64'(e.rd));
        chk("mon_wdw", 64'(wdw), 64'(e.d));
        chk("mon_fwd_rd", 64'(fwd_rd), 64'(e.rd));
        chk("mon_fwd_data", 64'(fwd_data), 64'(e.d));
        chk("mon_fwd_valid", 64'(fwd_valid), 64'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  logic [2:0]  mx_op  [5];
  logic [31:0] mx_alu [5];
  logic [31:0] mx_exp [5];

  initial begin
    mx_op[0] = 3'b100; mx_alu[0] = 32'h0; mx_exp[0] = 32'h0000007F;
    mx_op[1] = 3'b000; mx_alu[1] = 32'h1; mx_exp[1] = 32'hFFFFFFF0;
    mx_op[2] = 3'b001; mx_alu[2] = 32'h2; mx_exp[2] = 32'hFFFF8001;
    mx_op[3] = 3'b101; mx_alu[3] = 32'h0; mx_exp[3] = 32'h0000F07F;
    mx_op[4] = 3'b010; mx_alu[4] = 32'h0; mx_exp[4] = 32'h8001F07F;

    rst = 1'b0; en = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_rd = '0; in_reg_we = 1'b0;
    in_wb_ctr = '0; in_op = '0; in_alu_res = '0; in_pcn = '0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    #3;
    chk("rst_wew", 64'(wew), 64'd0);
    chk("rst_stall", 64'(stall_req), 64'd0);
    chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("rst_rdw", 64'(rdw), 64'd0);
    chk("rst_wdw", 64'(wdw), 64'd0);
    chk("rst_instret", instret, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    push(5'd5, 32'h1234);
    send(5'd5, 1'b1, 2'b00, 3'b0, 32'h1234, 32'h0);
    @(negedge clk);
    chk("alu_wew", 64'(wew), 64'd1);
    chk("alu_instret_before", instret, 64'd0);
    tick();
    chk("alu_instret_after", instret, 64'd1);

    push(5'd1, 32'h00000104);
    send(5'd1, 1'b1, 2'b10, 3'b0, 32'hDEAD, 32'h00000104);
    tick();
    chk("jal_instret", instret, 64'd2);
    send(5'd0, 1'b1, 2'b10, 3'b0, 32'h0, 32'h00000104);
    @(negedge clk);
    chk("jal_rd0_wew", 64'(wew), 64'd0);
    tick();
    chk("jal_rd0_instret", instret, 64'd3);

    push(5'd7, 32'hFFFFFF80);
    send(5'd7, 1'b1, 2'b01, 3'b000, 32'h00000103, 32'h0);
    @(negedge clk);
    chk("ld3_c1_stall", 64'(stall_req), 64'd1);
    chk("ld3_c1_wew", 64'(wew), 64'd0);
    tick();
    @(negedge clk);
    chk("ld3_c2_stall", 64'(stall_req), 64'd1);
    chk("ld3_c2_wew", 64'(wew), 64'd0);
    chk("ld3_c2_fwd", 64'(fwd_valid), 64'd0);
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h80FF0000;
    push(5'd9, 32'h55);
    in_valid = 1'b1; in_rd = 5'd9; in_reg_we = 1'b1;
    in_wb_ctr = 2'b00; in_op = 3'b0; in_alu_res = 32'h55;
    @(negedge clk);
    chk("ld3_c3_stall", 64'(stall_req), 64'd0);
    chk("ld3_c3_wew", 64'(wew), 64'd1);
    tick();
    in_valid = 1'b0;
    mem_rsp_valid = 1'b0;
    chk("ld3_instret", instret, 64'd4);
    @(negedge clk);
    chk("ld3_next_wew", 64'(wew), 64'd1);
    tick();
    chk("ld3_next_instret", instret, 64'd5);

    for (int i = 0; i < 5; i++) begin
      push(5'(10 + i), mx_exp[i]);
      send(5'(10 + i), 1'b1, 2'b01, mx_op[i], mx_alu[i], 32'h0);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'h8001F07F;
      @(negedge clk);
      chk("mx_stall", 64'(stall_req), 64'd0);
      tick();
      mem_rsp_valid = 1'b0;
    end
    chk("mx_instret", instret, 64'd10);

    send(5'd20, 1'b1, 2'b01, 3'b010, 32'h0, 32'h0);
    @(negedge clk);
    chk("fl_stall", 64'(stall_req), 64'd1);
    tick();
    flush = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hCAFEBABE;
    @(negedge clk);
    chk("fl_wew", 64'(wew), 64'd0);
    tick();
    flush = 1'b0;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("fl_stall_after", 64'(stall_req), 64'd0);
    chk("fl_instret", instret, 64'd10);
    tick();
    mem_rsp_valid = 1'b1;
    @(negedge clk);
    chk("stray_wew", 64'(wew), 64'd0);
    chk("stray_stall", 64'(stall_req), 64'd0);
    tick();
    mem_rsp_valid = 1'b0;
    chk("stray_instret", instret, 64'd10);

    send(5'd21, 1'b1, 2'b01, 3'b010, 32'h0, 32'h0);
    @(negedge clk);
    chk("ar_stall_pre", 64'(stall_req), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_stall", 64'(stall_req), 64'd0);
    chk("ar_wew", 64'(wew), 64'd0);
    chk("ar_instret", instret, 64'd0);
    #1;
    rst = 1'b1;
    tick();
    push(5'd22, 32'h0000ABCD);
    send(5'd22, 1'b1, 2'b11, 3'b0, 32'h0000ABCD, 32'h0);
    tick();
    chk("ar_resume_instret", instret, 64'd1);

    tick();
    tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
